serial_adder: RTL

//   Bit-serial ripple adder: A + B + CIN, one full-adder step per clock, LSB first.

---
 rtl/arith_pkg.sv | 31 +++
 rtl/full_adder.sv | 26 ++
 rtl/serial_adder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
//   Shared definitions for the bit-serial arithmetic cells.
//   - state_e : FSM encoding used by the serial adder (IDLE / RUN / DONE;
//               encoding 2'd3 is unused and recovers to IDLE).
//   - clog2   : elaboration-time ceil(log2(value)), used to size counters.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//   Single-bit combinational full adder.
//   Ports:
//     a, b  in  1  addend bits
//     cin   in  1  carry in
//     s     out 1  sum bit  = a ^ b ^ cin
//     co    out 1  carry out = majority(a, b, cin)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign s        = half_sum ^ cin;
  assign co       = (a & b) | (cin & half_sum);

endmodule

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial ripple adder computing A + B + CIN, one full-adder step per
//   clock, LSB first. One full-adder cell plus three shift registers; a
//   result takes WIDTH cycles after the operands are accepted.
//   Parameters:
//     WIDTH      operand / sum width (>= 1)
//   Ports:
//     clk        in   1      rising-edge clock
//     rst_n      in   1      asynchronous active-low reset
//     in_valid   in   1      a, b, cin valid
//     in_ready   out  1      high in IDLE: operands can be accepted
//     a, b       in   WIDTH  operands (unsigned or two's complement)
//     cin        in   1      carry in
//     out_valid  out  1      high in DONE: sum, cout, ovf valid
//     out_ready  in   1      consumer takes the result
//     sum        out  WIDTH  (a + b + cin) mod 2^WIDTH, registered
//     cout       out  1      unsigned carry out, registered
//     ovf        out  1      signed overflow, registered
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // Counter only has to reach WIDTH-1; sized for WIDTH+1 values, min 1 bit.
  localparam int CNT_W_RAW = clog2(WIDTH + 1);
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               fa_s;
  logic               fa_co;
  logic [WIDTH-1:0]   sum_shifted;

  // The single arithmetic cell: always looks at the current LSBs.
  full_adder u_fa (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .co  (fa_co)
  );

  // New sum bit enters at the MSB so that after WIDTH steps the first
  // (LSB) bit has travelled down to bit 0.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_shifted = fa_s;
    end else begin : g_sum_wn
      assign sum_shifted = {fa_s, sum_sh_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_sh_d  = sum_sh_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_sh_d   = a;
          b_sh_d   = b;
          carry_d  = cin;
          sum_sh_d = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        sum_sh_d = sum_shifted;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = fa_co;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          // On the MSB step carry_q is the carry into the MSB.
          ovf_d   = carry_q ^ fa_co;
          cout_d  = fa_co;
          state_d = DONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign sum  = sum_sh_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
